// File: rtl/gpio_mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register map of the memory-mapped GPIO controller.
//               Offsets are word indices taken from addr[5:2].
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Word offset inside the 64-byte register window
  typedef logic [3:0] offset_t;

  // Size of the register window in bytes; the window is aligned to this
  localparam int unsigned WINDOW_BYTES = 64;

  // Word offsets (byte offset >> 2)
  localparam offset_t OFF_DATA_OUT   = 4'h0;  // 0x00 rw
  localparam offset_t OFF_DIR        = 4'h1;  // 0x04 rw, 1 = output
  localparam offset_t OFF_DATA_IN    = 4'h2;  // 0x08 ro, synchronised pads
  localparam offset_t OFF_IRQ_EN     = 4'h3;  // 0x0C rw
  localparam offset_t OFF_IRQ_EDGE   = 4'h4;  // 0x10 rw, 1 = rising
  localparam offset_t OFF_IRQ_STATUS = 4'h5;  // 0x14 write-one-to-clear

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_mmio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_mmio_ctrl_if
// Description : Data-memory bus between the core and the GPIO controller.
//               One-cycle we/re strobes, registered rdata with rvalid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_mmio_ctrl_if #(
  parameter int BIT_WIDTH = 32
);

  logic [BIT_WIDTH-1:0] addr;
  logic [BIT_WIDTH-1:0] wdata;
  logic                 we;
  logic                 re;
  logic [BIT_WIDTH-1:0] rdata;
  logic                 rvalid;

  // Core side
  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata,
    input  rvalid
  );

  // Peripheral side
  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata,
    output rvalid
  );

endinterface : gpio_mmio_ctrl_if
`default_nettype wire

// File: rtl/gpio_mmio_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync_edge
// Description : Two-flop synchroniser for asynchronous pad inputs followed
//               by a history register; produces per-pin rise/fall events.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
  parameter int GPIO_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,      // asynchronous, active low
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] sync2,
  output logic [GPIO_WIDTH-1:0] rise,
  output logic [GPIO_WIDTH-1:0] fall
);

  logic [GPIO_WIDTH-1:0] r_sync1;
  logic [GPIO_WIDTH-1:0] r_sync2;
  logic [GPIO_WIDTH-1:0] r_prev;

  // Metastability chain plus one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign sync2 = r_sync2;
  assign rise  = r_sync2 & ~r_prev;
  assign fall  = ~r_sync2 & r_prev;

endmodule : gpio_sync_edge
`default_nettype wire

// File: rtl/gpio_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_mmio_ctrl
// Description : Memory-mapped GPIO controller: per-pin direction, output
//               data, synchronised input sampling and per-pin edge
//               interrupts behind a 64-byte word-addressed window.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_mmio_ctrl
  import gpio_pkg::*;
#(
  parameter int                   BIT_WIDTH  = 32,
  parameter int                   GPIO_WIDTH = 9,
  parameter logic [BIT_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active low
  gpio_mmio_ctrl_if.slave       bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  // Register file
  logic [GPIO_WIDTH-1:0] r_data_out;
  logic [GPIO_WIDTH-1:0] r_dir;
  logic [GPIO_WIDTH-1:0] r_irq_en;
  logic [GPIO_WIDTH-1:0] r_irq_edge;
  logic [GPIO_WIDTH-1:0] r_irq_status;

  // Read return path
  logic [BIT_WIDTH-1:0]  r_rdata;
  logic                  r_rvalid;

  // Decode and datapath wires
  logic                  w_sel;
  offset_t               w_off;
  logic                  w_wr;
  logic                  w_rd;
  logic [GPIO_WIDTH-1:0] w_wval;
  logic [GPIO_WIDTH-1:0] w_sync2;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_fall;
  logic [GPIO_WIDTH-1:0] w_event;
  logic [GPIO_WIDTH-1:0] w_clr;
  logic [GPIO_WIDTH-1:0] w_rsel;
  logic [BIT_WIDTH-1:0]  w_rdata;

  // Byte lane bits and the upper write-data bits carry no information here
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

  // --------------------------------------------------------------------------
  // Pad input synchroniser and edge detector
  // --------------------------------------------------------------------------
  gpio_sync_edge #(
    .GPIO_WIDTH (GPIO_WIDTH)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .sync2   (w_sync2),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // --------------------------------------------------------------------------
  // Address decode: window match on the upper bits, word offset from [5:2]
  // --------------------------------------------------------------------------
  assign w_sel  = (bus.addr[BIT_WIDTH-1:6] == BASE_ADDR[BIT_WIDTH-1:6]);
  assign w_off  = offset_t'(bus.addr[5:2]);
  assign w_wr   = bus.we & w_sel;
  assign w_rd   = bus.re & w_sel;
  assign w_wval = bus.wdata[GPIO_WIDTH-1:0];

  // Only input pins capture events; IRQ_EDGE picks rising or falling per pin
  assign w_event = ~r_dir & ((r_irq_edge & w_rise) | (~r_irq_edge & w_fall));

  // Write-one-to-clear mask for the status register
  assign w_clr = (w_wr && (w_off == OFF_IRQ_STATUS)) ? w_wval : '0;

  // Configuration registers: written only on a selected, mapped offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_edge <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_DATA_OUT: r_data_out <= w_wval;
        OFF_DIR:      r_dir      <= w_wval;
        OFF_IRQ_EN:   r_irq_en   <= w_wval;
        OFF_IRQ_EDGE: r_irq_edge <= w_wval;
        default:      ;
      endcase
    end
  end

  // Sticky status: a new event overrides a same-cycle clear on that bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_status <= '0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_clr) | w_event;
    end
  end

  // --------------------------------------------------------------------------
  // Read path; registers are sampled before any same-cycle write lands
  // --------------------------------------------------------------------------

  // Select the register addressed by the current offset
  always_comb begin
    w_rsel = '0;
    case (w_off)
      OFF_DATA_OUT:   w_rsel = r_data_out;
      OFF_DIR:        w_rsel = r_dir;
      OFF_DATA_IN:    w_rsel = w_sync2;
      OFF_IRQ_EN:     w_rsel = r_irq_en;
      OFF_IRQ_EDGE:   w_rsel = r_irq_edge;
      OFF_IRQ_STATUS: w_rsel = r_irq_status;
      default:        w_rsel = '0;
    endcase
  end

  // Zero-extend the pin-wide value onto the bus width
  always_comb begin
    w_rdata                 = '0;
    w_rdata[GPIO_WIDTH-1:0] = w_rsel;
  end

  // Registered read data with a single-cycle valid pulse per selected read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

  // --------------------------------------------------------------------------
  // Pad and interrupt outputs
  // --------------------------------------------------------------------------
  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = |(r_irq_status & r_irq_en);

endmodule : gpio_mmio_ctrl
`default_nettype wire

// File: doc/gpio_mmio_ctrl.md
# gpio_mmio_ctrl

Memory-mapped, parametrised GPIO controller for the multicycle MIPS top level; the next generation of the fixed 9-bit output-only GPIO port. It gives the core per-pin direction control, synchronised input sampling and per-pin edge-triggered interrupts through a word-addressed register window. It sits on the data-memory bus beside RAM and drives the board pins.

## Interface
Parameters:
- BIT_WIDTH, 32, data/address bus width
- GPIO_WIDTH, 9, number of pins (1..BIT_WIDTH)
- BASE_ADDR, 32'h1001_0000, byte address of register window (64-byte aligned)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- addr  in  BIT_WIDTH  byte address from core
- wdata  in  BIT_WIDTH  write data
- we  in  1  write strobe, one cycle per access
- re  in  1  read strobe, one cycle per access
- rdata  out  BIT_WIDTH  registered read data
- rvalid  out  1  rdata valid, one-cycle pulse
- gpio_in  in  GPIO_WIDTH  asynchronous pad inputs
- gpio_out  out  GPIO_WIDTH  pad output values
- gpio_oe  out  GPIO_WIDTH  pad output enables (1 = drive)
- irq  out  1  level interrupt to core

## Operation
- Select: addr[BIT_WIDTH-1:6] == BASE_ADDR[BIT_WIDTH-1:6]; offset = addr[5:2]; addr[1:0] ignored.
- Registers (byte offsets): 0x00 DATA_OUT rw; 0x04 DIR rw (1 = output); 0x08 DATA_IN ro (synchronised pads); 0x0C IRQ_EN rw; 0x10 IRQ_EDGE rw (1 = rising, 0 = falling); 0x14 IRQ_STATUS w1c.
- Writes use wdata[GPIO_WIDTH-1:0]; reads are zero-extended to BIT_WIDTH.
- Unmapped offset or unselected address: write ignored; read returns 0 with rvalid still pulsed if selected, no rvalid if unselected.
- gpio_out = DATA_OUT; gpio_oe = DIR. DATA_OUT reads back the register, not the pad.
- Input path per pin: sync1 -> sync2 -> prev. Rising event = sync2 & ~prev; falling = ~sync2 & prev; the IRQ_EDGE bit selects which one applies.
- Events are captured into IRQ_STATUS only on pins with DIR = 0; IRQ_EN does not gate capture.
- irq = |(IRQ_STATUS & IRQ_EN), combinational from registers.
- Same-cycle W1C and new event on a bit: set wins.
- we and re asserted together: write performed; read returns the pre-write value.
- Reset values: DATA_OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STATUS, sync1/sync2/prev = 0; rdata = 0, rvalid = 0, gpio_out = 0, gpio_oe = 0, irq = 0. Reset mid-access aborts the access; no rvalid follows.

## Timing
- Write: register updated at the clock edge sampling we; visible on pads/irq the following cycle.
- Read: re sampled at edge k -> rdata/rvalid valid in cycle after k, rvalid high exactly one cycle. Back-to-back reads are allowed every cycle.
- Pad change before edge k: sync1 at k, sync2 at k+1 (DATA_IN readable with re at k+2), status set at edge k+2, irq high after k+2 if enabled.
- Pulses shorter than one clock period may be missed; no glitch filtering.
- Changing IRQ_EDGE or DIR creates no spurious event beyond what sync2/prev produce on the next cycle.

## Structure
- Package gpio_pkg: register offset constants (OFF_DATA_OUT .. OFF_IRQ_STATUS), the 4-bit offset typedef, window size constant.
- Sub-module gpio_sync_edge: GPIO_WIDTH-wide two-flop synchroniser plus prev register; outputs sync2, rise and fall vectors. Same clk/rst.
- Top: address decode, register file, status update, read mux/register.

## Test plan
- Reset: hold rst = 0 for 5 cycles -> all outputs 0; reads of every register return 0.
- Write DIR = 0x1FF, DATA_OUT = 0x155 -> gpio_oe = 0x1FF, gpio_out = 0x155 next cycle; read 0x00 -> 0x0000_0155 with one-cycle rvalid.
- DIR = 0, IRQ_EN = 0x001, IRQ_EDGE = 0x001; gpio_in[0] 0->1 before edge k -> IRQ_STATUS = 0x001 and irq = 1 after edge k+2; W1C 0x001 -> irq = 0.
- Falling edge on pin 3 with IRQ_EDGE[3] = 0, IRQ_EN = 0 -> status bit 3 set, irq stays 0; enabling IRQ_EN[3] raises irq.
- W1C of bit 0 in the same cycle as a new rising event on pin 0 -> bit remains 1.
- Access with BASE_ADDR + 0x40 and with offset 0x18 -> no register change; offset 0x18 read returns 0 with rvalid, out-of-window read gives no rvalid.
